// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: pipeline <-> HI/LO mul/div unit bundle.
//   master (pipeline EX stage): drives start/op/Adata/Bdata/mthi/mtlo,
//                               observes busy/done/hi/lo.
//   slave  (hilo_muldiv):       the reverse.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] Adata;
  logic [WIDTH-1:0] Bdata;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, Adata, Bdata, mthi, mtlo,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, Adata, Bdata, mthi, mtlo,
                  output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of hilo_muldiv_if
//              start/op/Adata/Bdata launch an op (IDLE only),
//              mthi/mtlo write Adata into HI/LO (IDLE only, start wins),
//              busy high while an op is in flight, done pulses after the
//              HI/LO result write, hi/lo are the architectural registers.
// Operands are reduced to magnitudes at launch; 32 shift-add or restoring
// divide iterations follow, then one FIX cycle applies the signs.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  hilo_muldiv_if.slave   bus
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            div_q,   div_d;    // op[1]: divide vs multiply
  logic            sa_q,    sa_d;     // operand signs, only set for signed ops
  logic            sb_q,    sb_d;
  logic [W-1:0]    araw_q,  araw_d;   // raw dividend for the divide-by-zero HI
  logic [W-1:0]    a_q,     a_d;      // multiplicand / dividend magnitude
  logic [W-1:0]    b_q,     b_d;      // divisor magnitude
  logic [2*W-1:0]  prod_q,  prod_d;   // {partial product, remaining multiplier}
  logic [W-1:0]    rem_q,   rem_d;    // partial remainder
  logic [W-1:0]    quo_q,   quo_d;    // dividend bits shift out, quotient bits in
  logic [W-1:0]    hi_q,    hi_d;
  logic [W-1:0]    lo_q,    lo_d;
  logic            done_q,  done_d;

  logic            a_neg, b_neg;
  logic [W:0]      sum;     // shift-add carry fits in one extra bit
  logic [W:0]      trial;   // 33-bit partial remainder for this step
  logic [2*W-1:0]  prod_fix;

  // Sign of an operand matters only for the signed ops (op[0] == 0).
  assign a_neg = ~bus.op[0] & bus.Adata[W-1];
  assign b_neg = ~bus.op[0] & bus.Bdata[W-1];

  assign sum      = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign trial    = {rem_q, quo_q[W-1]};
  assign prod_fix = (sa_q ^ sb_q) ? -prod_q : prod_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    araw_d  = araw_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          div_d   = bus.op[1];
          sa_d    = a_neg;
          sb_d    = b_neg;
          araw_d  = bus.Adata;
          a_d     = a_neg ? -bus.Adata : bus.Adata;
          b_d     = b_neg ? -bus.Bdata : bus.Bdata;
          prod_d  = {{W{1'b0}}, (b_neg ? -bus.Bdata : bus.Bdata)};
          rem_d   = '0;
          quo_d   = a_neg ? -bus.Adata : bus.Adata;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          if (bus.mthi) hi_d = bus.Adata;
          if (bus.mtlo) lo_d = bus.Adata;
        end
      end
      CALC: begin
        if (div_q) begin
          // Restoring step: the remainder stays below the divisor, so the
          // subtracted result always fits back into W bits.
          if (trial >= {1'b0, b_q}) begin
            rem_d = W'(trial - {1'b0, b_q});
            quo_d = {quo_q[W-2:0], 1'b1};
          end else begin
            rem_d = trial[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
          end
        end else begin
          prod_d = {sum, prod_q[W-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) state_d = FIX;
      end
      FIX: begin
        if (!div_q) begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end else if (b_q == '0) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          // Quotient sign from the operand signs, remainder from the dividend.
          lo_d = (sa_q ^ sb_q) ? -quo_q : quo_q;
          hi_d = sa_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      araw_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      araw_q  <= araw_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
